// File: rtl/sd_fifo_tx_filler_if.sv
// Wishbone classic read-master bus used by the SD transmit filler.
interface sd_fifo_tx_filler_if;
  logic [31:0] m_wb_adr_o;
  logic        m_wb_we_o;
  logic [31:0] m_wb_dat_i;
  logic        m_wb_cyc_o;
  logic        m_wb_stb_o;
  logic        m_wb_ack_i;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o;

  modport master (
    output m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    input  m_wb_dat_i, m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    output m_wb_dat_i, m_wb_ack_i
  );
endinterface

// File: rtl/sd_fifo_tx_filler.sv
// SD transmit DMA filler: Wishbone reads from memory into a dual-clock FIFO
// that the serial transmitter drains in the sd_clk domain.
module sd_fifo_tx_filler #(
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned MEM_OFFSET = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  sd_fifo_tx_filler_if.master        wb,
  input  logic                       en,
  input  logic [31:0]                adr,
  input  logic                       sd_clk,
  input  logic                       rd,
  output logic [31:0]                dat_o,
  output logic                       empty
);
  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic {StIdle, StReq} state_e;

  state_e           state_q, state_d;
  logic [8:0]       offset_q, offset_d;
  logic             fifo_rst_q;
  logic             fifo_clr;
  logic             wr_en, rd_en, wfull, in_req;
  logic [31:0]      mem [Depth];
  logic [FIFO_AW:0] wr_bin_q, wr_gray_q, wr_bin_next;
  logic [FIFO_AW:0] rd_bin_q, rd_gray_q, rd_bin_next;
  logic [FIFO_AW:0] rq1_q, rq2_q, wq1_q, wq2_q;

  // Held high while en=0 so both FIFO domains stay flushed until fetching resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fifo_rst_q <= 1'b1;
    else     fifo_rst_q <= ~en;
  end

  assign fifo_clr = rst | fifo_rst_q;

  // Master FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
    end
  end

  // Master FSM: next state
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    if (!en) begin
      state_d  = StIdle;
      offset_d = '0;
    end else begin
      case (state_q)
        StIdle: if (!fifo_rst_q && !wfull) state_d = StReq;
        StReq: begin
          if (wb.m_wb_ack_i) begin
            state_d  = StIdle;
            offset_d = offset_q + 9'(MEM_OFFSET);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Master FSM: outputs
  always_comb begin
    in_req        = (state_q == StReq);
    wb.m_wb_cyc_o = in_req;
    wb.m_wb_stb_o = in_req;
    wr_en         = in_req && wb.m_wb_ack_i && en;
  end

  assign wb.m_wb_adr_o = adr + {23'd0, offset_q};
  assign wb.m_wb_we_o  = 1'b0;
  assign wb.m_wb_cti_o = 3'b000;
  assign wb.m_wb_bte_o = 2'b00;

  // Write side
  assign wr_bin_next = wr_bin_q + PtrOne;

  always_ff @(posedge clk or posedge fifo_clr) begin
    if (fifo_clr) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      rq1_q     <= '0;
      rq2_q     <= '0;
    end else begin
      rq1_q <= rd_gray_q;
      rq2_q <= rq1_q;
      if (wr_en) begin
        wr_bin_q  <= wr_bin_next;
        wr_gray_q <= wr_bin_next ^ (wr_bin_next >> 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bin_q[FIFO_AW-1:0]] <= wb.m_wb_dat_i;
  end

  // Full when the Gray pointers differ only in their two MSBs.
  assign wfull = (wr_gray_q == {~rq2_q[FIFO_AW -: 2], rq2_q[FIFO_AW-2:0]});

  // Read side
  assign empty       = (rd_gray_q == wq2_q);
  assign rd_en       = rd & ~empty;
  assign rd_bin_next = rd_bin_q + PtrOne;

  always_ff @(posedge sd_clk or posedge fifo_clr) begin
    if (fifo_clr) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      wq1_q     <= '0;
      wq2_q     <= '0;
      dat_o     <= '0;
    end else begin
      wq1_q <= wr_gray_q;
      wq2_q <= wq1_q;
      if (rd_en) begin
        dat_o     <= mem[rd_bin_q[FIFO_AW-1:0]];
        rd_bin_q  <= rd_bin_next;
        rd_gray_q <= rd_bin_next ^ (rd_bin_next >> 1);
      end
    end
  end
endmodule

// File: tb/tb_sd_fifo_tx_filler.sv
// Self-checking bench for sd_fifo_tx_filler: random Wishbone slave and popper,
// queue-based reference model of the word stream and address sequence.
module tb_sd_fifo_tx_filler;
  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        sd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] adr = 32'h0000_1000;
  logic [31:0] dat_o;
  logic        empty;

  sd_fifo_tx_filler_if wb();

  sd_fifo_tx_filler #(.FIFO_AW(3), .MEM_OFFSET(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .wb     (wb),
    .en     (en),
    .adr    (adr),
    .sd_clk (sd_clk),
    .rd     (rd),
    .dat_o  (dat_o),
    .empty  (empty)
  );

  always #5 clk = ~clk;
  always #15 sd_clk = ~sd_clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  logic [31:0] last_dat = 32'd0;
  logic [31:0] e;
  int k = 0;
  int acks = 0;
  int seq = 0;
  int wait_cnt = 0;
  int wait_target = 0;
  int wait_lo = 0;
  int wait_hi = 0;
  bit slave_hold = 1'b0;
  int rd_pct = 0;
  bit pop_pend = 1'b0;
  bit rd_was = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  // Wishbone slave and bus monitor
  always @(negedge clk) begin
    if (rst) begin
      wb.m_wb_ack_i = 1'b0;
      wb.m_wb_dat_i = 32'd0;
      wait_cnt = 0;
    end else if (wb.m_wb_cyc_o && !wb.m_wb_ack_i) begin
      if (en) check("wb_adr", wb.m_wb_adr_o, adr + 32'((k * 4) % 512));
      check("wb_stb", 32'(wb.m_wb_stb_o), 32'd1);
      check("wb_consts", {26'd0, wb.m_wb_we_o, wb.m_wb_cti_o, wb.m_wb_bte_o}, 32'd0);
      if (!slave_hold && wait_cnt >= wait_target) begin
        wb.m_wb_ack_i = 1'b1;
        wb.m_wb_dat_i = 32'hA0 + 32'(seq);
        seq++;
        if (en) begin
          if (k == 128) check("wrap_129th_adr", wb.m_wb_adr_o, adr);
          if (k == 129) check("wrap_130th_adr", wb.m_wb_adr_o, adr + 32'd4);
          exp_q.push_back(wb.m_wb_dat_i);
          k++;
          acks++;
          check("fifo_bound", 32'(exp_q.size() <= Depth), 32'd1);
        end
        wait_cnt = 0;
        wait_target = $urandom_range(wait_hi, wait_lo);
      end else begin
        wait_cnt++;
      end
    end else begin
      wb.m_wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
  end

  // Read-side popper and data monitor
  always @(negedge sd_clk) begin
    if (pop_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_underflow actual=%h required=no_pop at %0t", dat_o, $time);
      end else begin
        e = exp_q.pop_front();
        check("dat_o_pop", dat_o, e);
        last_dat = e;
      end
    end else if (rd_was && !rst && en) begin
      check("dat_o_hold", dat_o, last_dat);
    end
    rd = ($urandom_range(99, 0) < rd_pct);
    rd_was = rd;
    pop_pend = rd && !empty;
  end

  task automatic run_acks(input int n, input string name);
    int target = acks + n;
    int cnt = 0;
    while (acks < target && cnt < n * 20 + 200) begin
      @(posedge clk);
      cnt++;
    end
    if (acks < target) fail_now(name);
  endtask

  task automatic drain(input string name);
    int cnt = 0;
    slave_hold = 1'b1;
    rd_pct = 100;
    while (exp_q.size() != 0 && cnt < 400) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) fail_now({name, "_timeout"});
    repeat (4) @(negedge sd_clk);
    check(name, 32'(empty), 32'd1);
  endtask

  task automatic wait_cyc(input string name);
    int cnt = 0;
    @(posedge clk); #2;
    while (!wb.m_wb_cyc_o && cnt < 300) begin
      @(posedge clk); #2;
      cnt++;
    end
    if (!wb.m_wb_cyc_o) fail_now(name);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb.m_wb_stb_o), 32'd0);
    check("rst_consts", {26'd0, wb.m_wb_we_o, wb.m_wb_cti_o, wb.m_wb_bte_o}, 32'd0);
    check("rst_adr", wb.m_wb_adr_o, adr);
    check("rst_dat", dat_o, 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("idle_cyc", 32'(wb.m_wb_cyc_o), 32'd0);

    // Fill to full with a zero-wait slave and no popping
    en = 1'b1;
    @(posedge clk); #2;
    check("en_lat_n", 32'(wb.m_wb_cyc_o), 32'd0);
    @(posedge clk); #2;
    check("en_lat_n1", 32'(wb.m_wb_cyc_o), 32'd1);
    repeat (14) @(posedge clk);
    #2;
    check("zero_wait_rate7", 32'(acks), 32'd7);
    @(posedge clk); #2;
    check("zero_wait_rate8", 32'(acks), 32'd8);
    repeat (40) @(posedge clk);
    #2;
    check("fill_count", 32'(acks), 32'd8);
    check("fill_cyc_idle", 32'(wb.m_wb_cyc_o), 32'd0);
    check("fill_not_empty", 32'(empty), 32'd0);

    // Drain while fetching continues, then stop the slave and empty out
    rd_pct = 100;
    repeat (60) @(posedge clk);
    drain("drain_empty");

    // Fixed wait states, then random waits and random popping
    wait_lo = 5; wait_hi = 5; wait_target = 5;
    rd_pct = 50;
    slave_hold = 1'b0;
    run_acks(16, "wait5_progress");
    wait_lo = 0; wait_hi = 3;
    rd_pct = 70;
    run_acks(60, "random_progress");
    drain("random_empty");

    // Abort in REQ with three words buffered
    rd_pct = 0;
    repeat (3) @(negedge sd_clk);
    wait_lo = 2; wait_hi = 4; wait_target = 2;
    slave_hold = 1'b0;
    cnt = 0;
    @(posedge clk); #2;
    while (!(exp_q.size() == 3 && wb.m_wb_cyc_o) && cnt < 300) begin
      @(posedge clk); #2;
      cnt++;
    end
    if (cnt >= 300) fail_now("abort_setup");
    en = 1'b0;
    exp_q.delete();
    k = 0;
    last_dat = 32'd0;
    @(posedge clk); #2;
    check("abort_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
    check("abort_adr", wb.m_wb_adr_o, adr);
    repeat (3) @(posedge sd_clk);
    #1;
    check("abort_empty", 32'(empty), 32'd1);
    check("abort_dat", dat_o, 32'd0);

    // Re-enable at a new base and stream past the 512-byte offset wrap
    adr = 32'h2000_0100;
    wait_lo = 0; wait_hi = 0; wait_target = 0;
    rd_pct = 100;
    @(posedge clk); #2;
    en = 1'b1;
    run_acks(131, "wrap_progress");
    check("wrap_count", 32'(k >= 131), 32'd1);

    // Asynchronous reset in the middle of a request
    slave_hold = 1'b1;
    rd_pct = 0;
    repeat (3) @(negedge sd_clk);
    wait_cyc("rst_mid_setup");
    rst = 1'b1;
    exp_q.delete();
    k = 0;
    last_dat = 32'd0;
    #1;
    check("rst_mid_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
    check("rst_mid_stb", 32'(wb.m_wb_stb_o), 32'd0);
    check("rst_mid_dat", dat_o, 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_adr", wb.m_wb_adr_o, adr);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sd_fifo_tx_filler.md
# sd_fifo_tx_filler

Transmit-side DMA filler for the SD card host data path. A Wishbone master fetches consecutive 32-bit words from system memory starting at `adr` and pushes them into an internal dual-clock FIFO. The SD serial data transmitter pops those words in the `sd_clk` domain. The block mirrors the receive filler: memory → FIFO → card, instead of card → FIFO → memory.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW words of 32 bits.
- `MEM_OFFSET`, 4: byte increment of the Wishbone address per completed word.

- `clk` in 1: Wishbone/system clock; all master logic and the FIFO write side.
- `rst` in 1: reset, asynchronous, active-high; clears both clock domains.
- `m_wb_adr_o` out 32: `adr + offset`, combinational; `offset` is 9-bit, zero-extended.
- `m_wb_we_o` out 1: constant 0 (read-only master).
- `m_wb_dat_i` in 32: read data, sampled on the cycle `m_wb_ack_i`=1.
- `m_wb_cyc_o` out 1: bus cycle.
- `m_wb_stb_o` out 1: strobe; always equal to `m_wb_cyc_o`.
- `m_wb_ack_i` in 1: slave acknowledge.
- `m_wb_cti_o` out 3: constant 3'b000 (classic cycle).
- `m_wb_bte_o` out 2: constant 2'b00.
- `en` in 1: clk domain. 1 = fetch; 0 = abort, flush and hold idle.
- `adr` in 32: base byte address; stable while `en`=1.
- `sd_clk` in 1: serial-side clock; FIFO read side; asynchronous to `clk`.
- `rd` in 1: `sd_clk` domain pop request.
- `dat_o` out 32: `sd_clk` domain registered FIFO head word.
- `empty` out 1: `sd_clk` domain FIFO empty flag.

## Operation
- **FIFO**
  - Storage: 2^FIFO_AW × 32 RAM; write in clk, read in `sd_clk`.
  - Pointers: binary plus Gray, FIFO_AW+1 bits each. Each Gray pointer crosses to the other domain through a 2-flop synchronizer.
  - `wfull` (clk domain) compares the local write Gray pointer against the synchronized read pointer. `empty` (`sd_clk` domain) compares the local read Gray pointer against the synchronized write pointer. Both flags are pessimistic.
  - Flush: `fifo_rst` is a clk-domain register, set on `rst` and on every clk edge with `en`=0, cleared on the first clk edge with `en`=1. `rst | fifo_rst` asynchronously clears both pointer sets, both synchronizer chains and `dat_o`.
- **Master FSM** (clk domain)
  - States: IDLE and REQ.
  - IDLE → REQ when `en`=1 and `wfull`=0. Set `cyc`/`stb`=1 on that edge.
  - REQ, `m_wb_ack_i`=1: write `m_wb_dat_i` into the FIFO and advance the write pointer on the same edge. Set `cyc`/`stb`=0, `offset += MEM_OFFSET` (mod 512), go to IDLE.
  - REQ, `ack`=0: hold `cyc`/`stb`/`adr`, wait indefinitely.
  - At most one outstanding access. A new request issues only when space exists, so a FIFO write never overflows.
  - `en`=0 in any state: next edge gives IDLE, `cyc`/`stb`=0, `offset`=0. Data from an `ack` arriving on that same edge is discarded.
- **Read side**
  - `rd`=1 and `empty`=0 at a `sd_clk` edge: `dat_o` ← head word, read pointer advances.
  - `rd`=1 with `empty`=1: ignored; `dat_o` and the pointer are unchanged.

## Timing
- Reset values: `cyc`/`stb`/`we`=0, `cti`=000, `bte`=00, `offset`=0, so `m_wb_adr_o`=`adr`. FSM=IDLE, `dat_o`=0, `empty`=1, `fifo_rst`=1.
- `en` 0→1 at edge N: `fifo_rst` clears at N. IDLE→REQ evaluates at N+1, so `cyc`=1 is visible after N+1.
- Zero-wait slave (`ack` in the first `cyc` cycle): one word every 2 clk cycles.
- Write → `empty` deasserts after 2–3 `sd_clk` edges.
- Pop → `wfull` releases after 2–3 clk edges.
- Pop latency: `dat_o` is valid after the `sd_clk` edge that samples `rd`.
- Offset wrap: after 128 words with `MEM_OFFSET`=4, `offset` returns to 0 and the address returns to `adr`.

## Test plan
- **Reset:** assert `rst` mid-REQ (`cyc`=1) → `cyc`/`stb` drop immediately (asynchronously), `dat_o`=0, `empty`=1, `m_wb_adr_o`=`adr`.
- **Fill to full:** `adr`=0x1000, `en`=1, zero-wait slave returning 0xA0+i, `rd`=0 → exactly 8 reads at 0x1000..0x101C, then `cyc` stays 0.
- **Drain:** continuing the fill scenario, pop 8 words at `sd_clk`=3×clk → `dat_o` sequence 0xA0..0xA7 in order; 0x1020 fetched after first pop propagates; `empty`=1 once drained and no fetch pending.
- **Wait states:** slave `ack` after 5 cycles → `cyc`/`stb`/`adr` held for 5 cycles, one FIFO write per `ack`.
- **Abort:** drop `en` while in REQ with 3 words buffered → `cyc`=0 next edge, `offset`=0, `empty`=1 within 3 `sd_clk`. Re-raise `en` → first read at `adr`.
- **Wrap:** 130 words with continuous popping → 129th address equals `adr`, 130th equals `adr`+4.
